// File: rtl/obj_if.sv
// obj_if: command/response bundle between the command decoder and object_unit
interface obj_if #(parameter int ADDR_W = 16);
  logic              crt_obj;
  logic              del_obj;
  logic              del_all;
  logic              ref_addr;
  logic [4:0]        obj_num;
  logic              changed_in;
  logic              addr_vld;
  logic [4:0]        obj_id;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              full;
  logic              err;
  logic [31:0]       chg_mask;
  modport master (output crt_obj, del_obj, del_all, ref_addr, obj_num, changed_in,
                  input addr_vld, obj_id, addr, busy, full, err, chg_mask);
  modport slave  (input crt_obj, del_obj, del_all, ref_addr, obj_num, changed_in,
                  output addr_vld, obj_id, addr, busy, full, err, chg_mask);
endinterface

// File: rtl/object_unit.sv
// object_unit: 32-slot object allocator with lowest-free-ID scan; OBJ_UNIT_CHG_TRACK_EN enables per-slot changed flags
module object_unit #(
  parameter int NUM_OBJ   = 32,
  parameter int ADDR_W    = 16,
  parameter int OBJ_WORDS = 64
) (
  input logic   clk,
  input logic   rst,
  obj_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  logic [0:0]         state;
  logic [4:0]         ptr;
  logic [NUM_OBJ-1:0] valid;
  logic [NUM_OBJ-1:0] chg;
  logic               hit;
  function automatic logic [ADDR_W-1:0] base(input logic [4:0] id);
    return ADDR_W'(32'(id) * OBJ_WORDS);
  endfunction
  assign hit = (state == SCAN) && !valid[ptr];
  assign bus.full = &valid;
  assign bus.busy = (state == SCAN);
  assign bus.chg_mask = chg;
  // control FSM: scan for lowest free slot, answer lookups, flag errors
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      bus.addr_vld <= 1'b0;
      bus.err <= 1'b0;
      bus.obj_id <= '0;
      bus.addr <= '0;
    end else begin
      bus.addr_vld <= 1'b0;
      bus.err <= 1'b0;
      if (bus.del_all) state <= IDLE;
      else if (state == SCAN) begin
        if (hit) begin
          state <= IDLE;
          bus.addr_vld <= 1'b1;
          bus.obj_id <= ptr;
          bus.addr <= base(ptr);
        end else if (ptr == 5'd31) state <= IDLE;
        else ptr <= ptr + 5'd1;
      end else if (bus.crt_obj) begin
        if (bus.full) bus.err <= 1'b1;
        else begin
          state <= SCAN;
          ptr <= '0;
        end
      end else if (bus.ref_addr) begin
        if (valid[bus.obj_num]) begin
          bus.addr_vld <= 1'b1;
          bus.obj_id <= bus.obj_num;
          bus.addr <= base(bus.obj_num);
        end else bus.err <= 1'b1;
      end
    end
  end
  // valid bitmap: a scan hit lands after a same-cycle delete so the slot stays allocated
  always_ff @(posedge clk) begin
    if (rst || bus.del_all) valid <= '0;
    else begin
      if (bus.del_obj) valid[bus.obj_num] <= 1'b0;
      if (hit) valid[ptr] <= 1'b1;
    end
  end
`ifdef OBJ_UNIT_CHG_TRACK_EN
  // changed flags: set by marked lookups of live slots, cleared on delete or reallocation
  always_ff @(posedge clk) begin
    if (rst || bus.del_all) chg <= '0;
    else begin
      if (state == IDLE && !bus.crt_obj && bus.ref_addr && bus.changed_in && valid[bus.obj_num])
        chg[bus.obj_num] <= 1'b1;
      if (bus.del_obj) chg[bus.obj_num] <= 1'b0;
      if (hit) chg[ptr] <= 1'b0;
    end
  end
`else
  logic unused_chg;
  assign unused_chg = bus.changed_in;
  assign chg = '0;
`endif
endmodule

// File: tb/tb_object_unit.sv
// tb_object_unit: directed and random checks of object_unit against a slot-array model
module tb_object_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  obj_if #(.ADDR_W(16)) bus();
  object_unit #(.NUM_OBJ(32), .ADDR_W(16), .OBJ_WORDS(64)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef OBJ_UNIT_CHG_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif
  int compared = 0;
  int mismatched = 0;
  bit m_valid[32];
  bit m_chg[32];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic m_full();
    for (int i = 0; i < 32; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [31:0] m_chgv();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = TRACK & m_chg[i];
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit c, input bit d, input bit da, input bit r, input int n, input bit ch);
    bus.crt_obj = c; bus.del_obj = d; bus.del_all = da; bus.ref_addr = r;
    bus.obj_num = 5'(n); bus.changed_in = ch;
    tick();
    bus.crt_obj = 0; bus.del_obj = 0; bus.del_all = 0; bus.ref_addr = 0; bus.changed_in = 0;
  endtask
  task automatic state_chk(input string tag);
    chk({tag, " full"}, bus.full, m_full());
    chk({tag, " chg_mask"}, bus.chg_mask, m_chgv());
  endtask
  task automatic create(input string tag);
    int k = -1;
    int e = 0;
    for (int i = 31; i >= 0; i--) if (!m_valid[i]) k = i;
    drive(1, 0, 0, 0, 0, 0);
    if (k < 0) begin
      chk({tag, " err"}, bus.err, 1);
      chk({tag, " addr_vld"}, bus.addr_vld, 0);
      return;
    end
    chk({tag, " busy"}, bus.busy, 1);
    while (!bus.addr_vld && e < 40) begin tick(); e++; end
    chk({tag, " latency"}, e + 1, k + 2);
    chk({tag, " obj_id"}, bus.obj_id, k);
    chk({tag, " addr"}, bus.addr, k * 64);
    chk({tag, " busy_done"}, bus.busy, 0);
    m_valid[k] = 1; m_chg[k] = 0;
  endtask
  task automatic del(input int n);
    drive(0, 1, 0, 0, n, 0);
    m_valid[n] = 0; m_chg[n] = 0;
  endtask
  task automatic delall();
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_chg[i] = 0; end
    chk("delall busy", bus.busy, 0);
  endtask
  task automatic do_ref(input string tag, input int n, input bit ch);
    drive(0, 0, 0, 1, n, ch);
    if (m_valid[n]) begin
      chk({tag, " addr_vld"}, bus.addr_vld, 1);
      chk({tag, " err"}, bus.err, 0);
      chk({tag, " obj_id"}, bus.obj_id, n);
      chk({tag, " addr"}, bus.addr, n * 64);
      if (ch) m_chg[n] = 1;
    end else begin
      chk({tag, " addr_vld"}, bus.addr_vld, 0);
      chk({tag, " err"}, bus.err, 1);
    end
  endtask
  initial begin
    int e;
    rst = 1;
    bus.crt_obj = 0; bus.del_obj = 0; bus.del_all = 0; bus.ref_addr = 0;
    bus.obj_num = 0; bus.changed_in = 0;
    repeat (3) tick();
    rst = 0;
    chk("rst addr_vld", bus.addr_vld, 0);
    chk("rst obj_id", bus.obj_id, 0);
    chk("rst addr", bus.addr, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst err", bus.err, 0);
    state_chk("rst");
    repeat (5) create("c5");
    state_chk("after5");
    del(3);
    create("recreate3");
    del(0); del(4);
    create("re0");
    create("re4");
    repeat (2) tick();
    chk("hold obj_id", bus.obj_id, 4);
    chk("hold addr", bus.addr, 256);
    delall();
    state_chk("delall");
    do_ref("ref_invalid", 2, 0);
    create("after_delall");
    repeat (31) create("fill");
    state_chk("full");
    create("overflow");
    state_chk("overflow");
    delall();
    create("chg0"); create("chg1");
    do_ref("chg_ref1", 1, 1);
    state_chk("chg_set");
    del(1);
    state_chk("chg_del");
    delall();
    repeat (6) create("scan_pre");
    drive(1, 0, 0, 0, 0, 0);
    chk("scan_del busy", bus.busy, 1);
    drive(0, 1, 0, 0, 2, 0);
    m_valid[2] = 0;
    e = 1;
    while (!bus.addr_vld && e < 40) begin tick(); e++; end
    chk("scan_del edges", e, 3);
    chk("scan_del obj_id", bus.obj_id, 2);
    m_valid[2] = 1;
    state_chk("scan_del");
    for (int it = 0; it < 120; it++) begin
      int op = $urandom_range(0, 19);
      int n = $urandom_range(0, 31);
      if (op < 8) create("rnd_create");
      else if (op < 13) del(n);
      else if (op < 19) do_ref("rnd_ref", n, 1'($urandom_range(0, 1)));
      else delall();
      state_chk("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
